// File: rtl/traffic_phase_scheduler.sv
// Demand-driven green/yellow/all-red phase scheduler for a four-way junction.
// One approach is green at a time, chosen by round-robin over sensor requests or by emergency preemption.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 20,
  parameter int GREEN_MAX = 60,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2,
  parameter int CW        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] emerg_req,
  output logic [3:0] red,
  output logic [3:0] yellow,
  output logic [3:0] green,
  output logic [1:0] active_dir,
  output logic       emerg_active
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  localparam logic [CW-1:0] ALLRED_LAST    = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] YELLOW_LAST    = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] GREEN_MIN_LAST = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GREEN_MAX_LAST = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] TIMER_SAT      = {CW{1'b1}};

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    dir_onehot = 4'b0001 << d;
  endfunction

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0]) begin
      lowest_set = 2'd0;
    end else if (v[1]) begin
      lowest_set = 2'd1;
    end else if (v[2]) begin
      lowest_set = 2'd2;
    end else begin
      lowest_set = 2'd3;
    end
  endfunction

  // Rotate so bit 0 is the direction after 'last'; the served direction is searched last.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] last);
    logic [3:0] rot;
    logic [1:0] idx;
    rot = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      idx    = last + 2'(k + 1);
      rot[k] = v[idx];
    end
    rr_pick = last + 2'd1 + lowest_set(rot);
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] timer_r, timer_s;
  logic [1:0]    dir_r, dir_s;
  logic          emerg_r, emerg_s;
  logic [3:0]    red_r, yellow_r, green_r;
  logic [3:0]    red_s, yellow_s, green_s;

  logic [3:0] own_s;
  logic       other_emerg_s, other_req_s, keep_emerg_s, gap_out_s, max_out_s;

  assign own_s         = dir_onehot(dir_r);
  assign other_emerg_s = |(emerg_req & ~own_s);
  assign other_req_s   = |(req & ~own_s);
  assign keep_emerg_s  = emerg_r & emerg_req[dir_r];
  assign gap_out_s     = (timer_r >= GREEN_MIN_LAST) & ~req[dir_r] & other_req_s;
  assign max_out_s     = (timer_r >= GREEN_MAX_LAST) & other_req_s;

  // Next-state, served direction and preemption flag.
  always_comb begin
    state_s = state_r;
    dir_s   = dir_r;
    emerg_s = emerg_r;
    case (state_r)
      ST_ALLRED: begin
        if ((timer_r >= ALLRED_LAST) && ((|emerg_req) || (|req))) begin
          state_s = ST_GREEN;
          if (|emerg_req) begin
            dir_s   = lowest_set(emerg_req);
            emerg_s = 1'b1;
          end else begin
            dir_s   = rr_pick(req, dir_r);
            emerg_s = 1'b0;
          end
        end else begin
          state_s = ST_ALLRED;
        end
      end
      ST_GREEN: begin
        if (other_emerg_s) begin
          state_s = ST_YELLOW;
          emerg_s = 1'b0;
        end else if (keep_emerg_s) begin
          state_s = ST_GREEN;
        end else if (gap_out_s || max_out_s) begin
          state_s = ST_YELLOW;
          emerg_s = 1'b0;
        end else begin
          emerg_s = 1'b0;
        end
      end
      ST_YELLOW: begin
        if (timer_r >= YELLOW_LAST) begin
          state_s = ST_ALLRED;
        end else begin
          state_s = ST_YELLOW;
        end
      end
      default: begin
        state_s = ST_ALLRED;
        emerg_s = 1'b0;
      end
    endcase
  end

  // Phase timer: restarts on every state entry and saturates when a phase is held.
  always_comb begin
    timer_s = timer_r;
    if (state_s != state_r) begin
      timer_s = {CW{1'b0}};
    end else if (timer_r != TIMER_SAT) begin
      timer_s = timer_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      timer_s = timer_r;
    end
  end

  // Lamp decode of the upcoming state, registered below so lamps track the state register.
  always_comb begin
    red_s    = 4'b1111;
    yellow_s = 4'b0000;
    green_s  = 4'b0000;
    case (state_s)
      ST_GREEN: begin
        green_s = dir_onehot(dir_s);
        red_s   = ~dir_onehot(dir_s);
      end
      ST_YELLOW: begin
        yellow_s = dir_onehot(dir_s);
        red_s    = ~dir_onehot(dir_s);
      end
      default: begin
        red_s = 4'b1111;
      end
    endcase
  end

  // State, timer and lamp registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_ALLRED;
      timer_r  <= {CW{1'b0}};
      dir_r    <= 2'd0;
      emerg_r  <= 1'b0;
      red_r    <= 4'b1111;
      yellow_r <= 4'b0000;
      green_r  <= 4'b0000;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      dir_r    <= dir_s;
      emerg_r  <= emerg_s;
      red_r    <= red_s;
      yellow_r <= yellow_s;
      green_r  <= green_s;
    end
  end

  assign red          = red_r;
  assign yellow       = yellow_r;
  assign green        = green_r;
  assign active_dir   = dir_r;
  assign emerg_active = emerg_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: phase-level reference model compared every cycle,
// directed timing scenarios with literal expectations, then randomized request traffic.
module tb_traffic_phase_scheduler;

  localparam int GREEN_MIN = 20;
  localparam int GREEN_MAX = 60;
  localparam int YELLOW_T  = 5;
  localparam int ALLRED_T  = 2;
  localparam int CW        = 8;

  localparam int PH_CLEAR  = 0;
  localparam int PH_GREEN  = 1;
  localparam int PH_YELLOW = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] emerg_req = 4'b0000;
  logic [3:0] red, yellow, green;
  logic [1:0] active_dir;
  logic       emerg_active;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // Reference model: which phase is shown, for how many cycles so far, for whom.
  int m_phase = PH_CLEAR;
  int m_shown = 1;
  int m_dir   = 0;
  bit m_emerg = 1'b0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .emerg_req(emerg_req),
    .red(red), .yellow(yellow), .green(green),
    .active_dir(active_dir), .emerg_active(emerg_active)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int first_set(input logic [3:0] v, input int start);
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = PH_CLEAR;
    m_shown = 1;
    m_dir   = 0;
    m_emerg = 1'b0;
  endtask

  task automatic model_to_yellow();
    m_phase = PH_YELLOW;
    m_shown = 1;
    m_emerg = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] own;
    own = 4'b0001 << m_dir;
    if (m_phase == PH_CLEAR) begin
      if (m_shown >= ALLRED_T && (emerg_req != 4'b0000 || req != 4'b0000)) begin
        if (emerg_req != 4'b0000) begin
          m_dir   = first_set(emerg_req, 0);
          m_emerg = 1'b1;
        end else begin
          m_dir   = first_set(req, m_dir + 1);
          m_emerg = 1'b0;
        end
        m_phase = PH_GREEN;
        m_shown = 1;
      end else m_shown++;
    end else if (m_phase == PH_GREEN) begin
      if ((emerg_req & ~own) != 4'b0000) model_to_yellow();
      else if (m_emerg && emerg_req[m_dir]) m_shown++;
      else begin
        m_emerg = 1'b0;
        if ((req & ~own) != 4'b0000 &&
            ((m_shown >= GREEN_MIN && !req[m_dir]) || m_shown >= GREEN_MAX)) model_to_yellow();
        else m_shown++;
      end
    end else begin
      if (m_shown >= YELLOW_T) begin
        m_phase = PH_CLEAR;
        m_shown = 1;
      end else m_shown++;
    end
  endtask

  function automatic logic [3:0] exp_lamp(input int kind);
    logic [3:0] own;
    own = 4'b0001 << m_dir;
    case (kind)
      0: return (m_phase == PH_GREEN) ? own : 4'b0000;
      1: return (m_phase == PH_YELLOW) ? own : 4'b0000;
      default: return (m_phase == PH_CLEAR) ? 4'b1111 : ~own;
    endcase
  endfunction

  function automatic logic [3:0] lamp(input int kind);
    case (kind)
      0: return green;
      1: return yellow;
      default: return red;
    endcase
  endfunction

  // Model advances on the same edge the DUT samples its inputs.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model plus lamp invariants.
  initial begin
    int bad_dirs;
    forever begin
      @(negedge clk);
      if (check_en && !reset) begin
        check("green", int'(green), int'(exp_lamp(0)));
        check("yellow", int'(yellow), int'(exp_lamp(1)));
        check("red", int'(red), int'(exp_lamp(2)));
        check("active_dir", int'(active_dir), m_dir);
        check("emerg_active", int'(emerg_active), int'(m_emerg && m_phase == PH_GREEN));
        bad_dirs = 0;
        for (int d = 0; d < 4; d++) begin
          if ($countones({red[d], yellow[d], green[d]}) != 1) bad_dirs++;
        end
        check("one_lamp_per_dir", bad_dirs, 0);
        check("at_most_one_nonred", int'($countones(~red) <= 1), 1);
      end
    end
  end

  task automatic wait_lamp(input int kind, input logic [3:0] val, input string name);
    int n;
    n = 0;
    while (lamp(kind) != val && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(lamp(kind)), int'(val));
  endtask

  task automatic count_while(input int kind, input logic [3:0] val, output int n);
    n = 0;
    while (lamp(kind) == val && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    #2;
    check("rst_red", int'(red), 4'hF);
    check("rst_yellow", int'(yellow), 0);
    check("rst_green", int'(green), 0);
    check("rst_active_dir", int'(active_dir), 0);
    check("rst_emerg_active", int'(emerg_active), 0);
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    check_en = 1'b1;

    // Idle junction stays all red; a lone S request wins next cycle.
    repeat (30) @(negedge clk);
    check("idle_red", int'(red), 4'hF);
    req = 4'b0100;
    @(negedge clk);
    check("s_green_next_cycle", int'(green), 4'b0100);
    check("s_active_dir", int'(active_dir), 2);

    // Saturated demand: max-out, full yellow and clearance, round-robin order.
    req = 4'b1111;
    wait_lamp(0, 4'b1000, "w_follows_s");
    count_while(0, 4'b1000, n);
    check("w_green_len", n, GREEN_MAX);
    count_while(1, 4'b1000, n);
    check("w_yellow_len", n, YELLOW_T);
    count_while(2, 4'b1111, n);
    check("allred_len", n, ALLRED_T);
    check("n_follows_w", int'(green), 4'b0001);
    wait_lamp(0, 4'b0010, "e_follows_n");

    // Lone N request: held indefinitely, then max-out as soon as E asks.
    req = 4'b0001;
    wait_lamp(0, 4'b0001, "n_green_reached");
    repeat (200) @(negedge clk);
    check("n_held_green", int'(green), 4'b0001);
    check("n_no_yellow", int'(yellow), 0);
    req = 4'b0011;
    @(negedge clk);
    check("n_maxout_yellow", int'(yellow), 4'b0001);

    // Gap-out: N drops its request at green cycle 3, green lasts GREEN_MIN.
    req = 4'b0001;
    wait_lamp(0, 4'b0001, "n_green_again");
    req = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    req = 4'b0010;
    count_while(0, 4'b0001, n);
    check("gap_out_green_len", n + 2, GREEN_MIN);
    check("gap_out_yellow", int'(yellow), 4'b0001);

    // Emergency for W preempts N at green cycle 2 and holds W.
    req = 4'b0001;
    wait_lamp(0, 4'b0001, "n_green_pre_emerg");
    @(negedge clk);
    emerg_req = 4'b1000;
    @(negedge clk);
    check("preempt_yellow", int'(yellow), 4'b0001);
    count_while(1, 4'b0001, n);
    check("preempt_yellow_len", n, YELLOW_T);
    count_while(2, 4'b1111, n);
    check("preempt_allred_len", n, ALLRED_T);
    check("w_emerg_green", int'(green), 4'b1000);
    check("w_emerg_flag", int'(emerg_active), 1);
    req = 4'b1111;
    repeat (100) @(negedge clk);
    check("w_emerg_hold", int'(green), 4'b1000);
    check("w_emerg_hold_flag", int'(emerg_active), 1);
    emerg_req = 4'b0000;
    @(negedge clk);
    check("emerg_release_yellow", int'(yellow), 4'b1000);
    check("emerg_release_flag", int'(emerg_active), 0);

    // Asynchronous reset during yellow; recovery search starts at E.
    #2 reset = 1'b1;
    #1;
    check("async_rst_red", int'(red), 4'hF);
    check("async_rst_yellow", int'(yellow), 0);
    check("async_rst_dir", int'(active_dir), 0);
    req = 4'b1010;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("recover_allred", int'(red), 4'hF);
    @(negedge clk);
    check("recover_e_first", int'(green), 4'b0010);

    // Randomized traffic checked by the per-cycle model comparison.
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0)
        emerg_req = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
